uart_rx: RTL and testbench

//   8N1 UART receiver. Drives i_Rx_Serial from the pin into a parallel byte with a one-cycle

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle for the 8N1 UART receiver.
// The master side drives the line and observes the received byte and strobes.
interface uart_rx_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Busy;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Frame_Err,
        input  o_Rx_Busy
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
        output o_Rx_Busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and 3-sample majority vote.
// Rejects false starts and flags framing errors, holding off in BREAK until idle.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic      i_Clock,
    input  logic      i_Rst_n,
    uart_rx_if.slave  rx
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_e;

    state_e          state_q;
    logic            meta_q;
    logic            rx_s_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;
    logic            s0_q;
    logic            s1_q;
    logic            dv_q;
    logic            fe_q;
    logic            busy_q;
    logic            last;
    logic            mid;
    logic            maj;

    assign last  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign mid   = (cnt_q == CW'(HALF + 1));
    assign cnt_d = last ? '0 : cnt_q + 1'b1;
    // third vote is the live sample taken at HALF+1
    assign maj   = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= rx.i_Rx_Serial;
            rx_s_q <= meta_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            fe_q <= 1'b0;
            if (cnt_q == CW'(HALF - 1)) s0_q <= rx_s_q;
            if (cnt_q == CW'(HALF))     s1_q <= rx_s_q;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (mid && maj) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (last) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (mid) shift_q[idx_q] <= maj;
                    if (last) begin
                        if (idx_q == 3'd7) state_q <= STOP;
                        else               idx_q   <= idx_q + 3'd1;
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    // leave mid-stop so a back-to-back start edge is not missed
                    if (mid) begin
                        if (maj) begin
                            byte_q  <= shift_q;
                            dv_q    <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= BRK;
                        end
                    end
                end
                BRK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.o_Rx_DV        = dv_q;
    assign rx.o_Rx_Byte      = byte_q;
    assign rx.o_Rx_Frame_Err = fe_q;
    assign rx.o_Rx_Busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Latencies measured from the first edge that samples the start bit low.
module tb_uart_rx;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_rx_if rx ();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .rx      (rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   dv_ts[$];
    int   dv_by[$];
    int   fe_ts[$];
    int   viol = 0;
    logic p_dv = 1'b0;
    logic p_fe = 1'b0;

    always @(negedge clk) begin
        if (rx.o_Rx_DV) begin
            dv_ts.push_back(cyc);
            dv_by.push_back(int'(rx.o_Rx_Byte));
        end
        if (rx.o_Rx_Frame_Err) fe_ts.push_back(cyc);
        if ((rx.o_Rx_DV && rx.o_Rx_Frame_Err) ||
            (rx.o_Rx_DV && p_dv) || (rx.o_Rx_Frame_Err && p_fe))
            viol = viol + 1;
        p_dv = rx.o_Rx_DV;
        p_fe = rx.o_Rx_Frame_Err;
    end

    task automatic check(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    // caller must be at a negedge; returns at a negedge
    task automatic send(input logic [7:0] b, input logic stop,
                        input int gbit, output int e0);
        rx.i_Rx_Serial = 1'b0;
        e0 = cyc + 1;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx.i_Rx_Serial = b[i];
            if (i == gbit) begin
                repeat (9) @(negedge clk);
                rx.i_Rx_Serial = ~b[i];
                @(negedge clk);
                rx.i_Rx_Serial = b[i];
                repeat (C - 10) @(negedge clk);
            end else begin
                repeat (C) @(negedge clk);
            end
        end
        rx.i_Rx_Serial = stop;
        repeat (C) @(negedge clk);
        rx.i_Rx_Serial = 1'b1;
    endtask

    int e0;
    int e1;
    int nd;
    int nf;
    int n;

    initial begin
        rx.i_Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", int'({rx.o_Rx_DV, rx.o_Rx_Frame_Err,
                                rx.o_Rx_Busy, rx.o_Rx_Byte}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(rx.o_Rx_Busy), 0);

        // 1: plain frame
        nd = dv_ts.size();
        nf = fe_ts.size();
        send(8'hA5, 1'b1, -1, e0);
        repeat (10) @(negedge clk);
        check("a5_dvcnt", dv_ts.size() - nd, 1);
        check("a5_lat", (dv_ts.size() > nd) ? dv_ts[nd] - e0 : -1, 156);
        check("a5_byte", int'(rx.o_Rx_Byte), 'hA5);
        check("a5_fe", fe_ts.size() - nf, 0);
        check("a5_busy", int'(rx.o_Rx_Busy), 0);

        // 2: false start
        nd = dv_ts.size();
        nf = fe_ts.size();
        n = 0;
        rx.i_Rx_Serial = 1'b0;
        e0 = cyc + 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 2) rx.i_Rx_Serial = 1'b1;
            if (rx.o_Rx_Busy) n = n + 1;
        end
        check("fs_busy", n, 10);
        check("fs_dv", dv_ts.size() - nd, 0);
        check("fs_fe", fe_ts.size() - nf, 0);

        // 3: line break
        nd = dv_ts.size();
        nf = fe_ts.size();
        rx.i_Rx_Serial = 1'b0;
        e0 = cyc + 1;
        repeat (20 * C) @(negedge clk);
        check("brk_busy", int'(rx.o_Rx_Busy), 1);
        check("brk_fe", fe_ts.size() - nf, 1);
        check("brk_lat", (fe_ts.size() > nf) ? fe_ts[nf] - e0 : -1, 156);
        check("brk_dv", dv_ts.size() - nd, 0);
        check("brk_byte", int'(rx.o_Rx_Byte), 'hA5);
        rx.i_Rx_Serial = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_idle", int'(rx.o_Rx_Busy), 0);
        repeat (20) @(negedge clk);

        // 4: one-cycle glitch on data bit 2
        nd = dv_ts.size();
        send(8'h3C, 1'b1, 2, e0);
        repeat (10) @(negedge clk);
        check("gl_dvcnt", dv_ts.size() - nd, 1);
        check("gl_byte", int'(rx.o_Rx_Byte), 'h3C);
        check("gl_lat", (dv_ts.size() > nd) ? dv_ts[nd] - e0 : -1, 156);

        // 5: back-to-back frames
        nd = dv_ts.size();
        send(8'h00, 1'b1, -1, e0);
        send(8'hFF, 1'b1, -1, e1);
        repeat (20) @(negedge clk);
        check("b2b_cnt", dv_ts.size() - nd, 2);
        check("b2b_gap", (dv_ts.size() > nd + 1) ?
              dv_ts[nd + 1] - dv_ts[nd] : -1, 160);
        check("b2b_b0", (dv_ts.size() > nd) ? dv_by[nd] : -1, 'h00);
        check("b2b_b1", (dv_ts.size() > nd + 1) ? dv_by[nd + 1] : -1, 'hFF);

        // 6: reset mid-frame
        nd = dv_ts.size();
        nf = fe_ts.size();
        rx.i_Rx_Serial = 1'b0;
        repeat (C) @(negedge clk);
        rx.i_Rx_Serial = 1'b1;
        repeat (C) @(negedge clk);
        rx.i_Rx_Serial = 1'b0;
        repeat (C) @(negedge clk);
        rx.i_Rx_Serial = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_outs", int'({rx.o_Rx_DV, rx.o_Rx_Frame_Err,
                               rx.o_Rx_Busy, rx.o_Rx_Byte}), 0);
        rx.i_Rx_Serial = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("mr_nostb", dv_ts.size() - nd + fe_ts.size() - nf, 0);
        send(8'h81, 1'b1, -1, e0);
        repeat (10) @(negedge clk);
        check("mr_dvcnt", dv_ts.size() - nd, 1);
        check("mr_byte", int'(rx.o_Rx_Byte), 'h81);
        check("mr_fe", fe_ts.size() - nf, 0);

        check("excl", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
